seven_seg_scan_capture: RTL and testbench

//  Reader side of the multiplexed 4-digit 7-segment display interface.
//  - Samples the active-low anode strobes and segment lines from the display driver.
//  - Waits for each digit slot to settle, then inverse-decodes the segment pattern to a hex nibble.
//  - Assembles the four nibbles into one frame and hands it off with a valid/ready handshake.
//  - Used as an in-system display monitor and as the self-check path for the display driver.

---
 rtl/seg7_pkg.sv | 39 +++
 rtl/seg7_glyph_decode.sv | 21 ++
 rtl/seven_seg_scan_capture.sv | 193 +++++++++++++++++++
 tb/tb_seven_seg_scan_capture.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, glyph table and anode helpers for the 7-segment scan reader.
package seg7_pkg;

    typedef enum logic [2:0] {
        HUNT,
        SETTLE,
        LATCH,
        WAIT,
        PUBLISH
    } scan_state_t;

    localparam logic [3:0] AN_BLANK = 4'hF;

    // Active-low {a,b,c,d,e,f,g}; b and d are the lower-case glyphs.
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic logic an_slot_valid(input logic [3:0] an);
        logic [3:0] low;
        low = ~an;
        return (low != 4'h0) && ((low & (low - 4'd1)) == 4'h0);
    endfunction

    function automatic logic [1:0] an_slot_idx(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Inverse glyph lookup: active-low a..g pattern to hex nibble plus error flag.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_abcdefg,
    output logic [3:0] nibble,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        err    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (seg_abcdefg == SEG_GLYPH[i]) begin
                nibble = 4'(i);
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Captures frames from a multiplexed 4-digit 7-segment display scan.
// Define SCAN_CONSEC_MATCH_EN to publish only frames that repeat back-to-back.
module seven_seg_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  seg,
    input  logic        frame_ready,
    output logic        frame_valid,
    output logic [15:0] value,
    output logic [3:0]  dp_bits,
    output logic [3:0]  seg_err,
    output logic        overrun
);

    scan_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]  snap_an_q, snap_an_d;
    logic [7:0]  snap_seg_q, snap_seg_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] slot_val_q, slot_val_d;
    logic [3:0]  slot_dp_q, slot_dp_d;
    logic [3:0]  slot_err_q, slot_err_d;
    logic        frame_valid_q, frame_valid_d;
    logic [15:0] value_q, value_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  err_q, err_d;
    logic        overrun_q, overrun_d;
`ifdef SCAN_CONSEC_MATCH_EN
    logic [23:0] cand_q, cand_d;
    logic        cand_vld_q, cand_vld_d;
`endif

    logic [3:0] dec_nib;
    logic       dec_err;
    logic       in_valid;
    logic       changed;
    logic       publish;
    logic [1:0] idx;

    seg7_glyph_decode u_dec (
        .seg_abcdefg (snap_seg_q[7:1]),
        .nibble      (dec_nib),
        .err         (dec_err)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        snap_an_d     = snap_an_q;
        snap_seg_d    = snap_seg_q;
        seen_d        = seen_q;
        slot_val_d    = slot_val_q;
        slot_dp_d     = slot_dp_q;
        slot_err_d    = slot_err_q;
        frame_valid_d = frame_valid_q;
        value_d       = value_q;
        dp_d          = dp_q;
        err_d         = err_q;
        overrun_d     = overrun_q;
`ifdef SCAN_CONSEC_MATCH_EN
        cand_d        = cand_q;
        cand_vld_d    = cand_vld_q;
`endif
        publish  = 1'b0;
        idx      = an_slot_idx(snap_an_q);
        in_valid = an_slot_valid(an) && (an != AN_BLANK);
        changed  = (an != snap_an_q) || (seg != snap_seg_q);

        if (frame_valid_q && frame_ready) begin
            frame_valid_d = 1'b0;
        end

        case (state_q)
            HUNT: begin
                cnt_d = '0;
                if (in_valid) begin
                    snap_an_d  = an;
                    snap_seg_d = seg;
                    cnt_d      = CNT_W'(1);
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (!in_valid) begin
                    cnt_d   = '0;
                    state_d = HUNT;
                end else if (changed) begin
                    snap_an_d  = an;
                    snap_seg_d = seg;
                    cnt_d      = CNT_W'(1);
                end else if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LATCH: begin
                slot_val_d[{idx, 2'b00} +: 4] = dec_nib;
                slot_dp_d[idx]  = ~snap_seg_q[0];
                slot_err_d[idx] = dec_err;
                seen_d  = seen_q | (4'b0001 << idx);
                cnt_d   = '0;
                state_d = (seen_d == 4'hF) ? PUBLISH : WAIT;
            end
            WAIT: begin
                if (an != snap_an_q) begin
                    state_d = HUNT;
                end
            end
            PUBLISH: begin
                seen_d  = 4'h0;
                state_d = WAIT;
`ifdef SCAN_CONSEC_MATCH_EN
                // A frame must repeat unchanged before it is trusted.
                if (cand_vld_q &&
                    (cand_q == {slot_val_q, slot_dp_q, slot_err_q})) begin
                    publish = 1'b1;
                end
                cand_d     = {slot_val_q, slot_dp_q, slot_err_q};
                cand_vld_d = 1'b1;
`else
                publish = 1'b1;
`endif
            end
            default: begin
                state_d = HUNT;
            end
        endcase

        if (publish) begin
            value_d       = slot_val_q;
            dp_d          = slot_dp_q;
            err_d         = slot_err_q;
            frame_valid_d = 1'b1;
            if (frame_valid_q && !frame_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= HUNT;
            cnt_q         <= '0;
            snap_an_q     <= AN_BLANK;
            snap_seg_q    <= 8'hFF;
            seen_q        <= 4'h0;
            slot_val_q    <= 16'h0;
            slot_dp_q     <= 4'h0;
            slot_err_q    <= 4'h0;
            frame_valid_q <= 1'b0;
            value_q       <= 16'h0;
            dp_q          <= 4'h0;
            err_q         <= 4'h0;
            overrun_q     <= 1'b0;
`ifdef SCAN_CONSEC_MATCH_EN
            cand_q        <= 24'h0;
            cand_vld_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            snap_an_q     <= snap_an_d;
            snap_seg_q    <= snap_seg_d;
            seen_q        <= seen_d;
            slot_val_q    <= slot_val_d;
            slot_dp_q     <= slot_dp_d;
            slot_err_q    <= slot_err_d;
            frame_valid_q <= frame_valid_d;
            value_q       <= value_d;
            dp_q          <= dp_d;
            err_q         <= err_d;
            overrun_q     <= overrun_d;
`ifdef SCAN_CONSEC_MATCH_EN
            cand_q        <= cand_d;
            cand_vld_q    <= cand_vld_d;
`endif
        end
    end

    assign frame_valid = frame_valid_q;
    assign value       = value_q;
    assign dp_bits     = dp_q;
    assign seg_err     = err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Bench for seven_seg_scan_capture: vector table plus scoreboard queue.
module tb_seven_seg_scan_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [7:0]  seg = 8'hFF;
    logic        frame_ready = 1'b1;
    logic        frame_valid;
    logic [15:0] value;
    logic [3:0]  dp_bits;
    logic [3:0]  seg_err;
    logic        overrun;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  err;
    } exp_t;

    typedef struct {
        logic [31:0] segs;
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  err;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[5];

    always #5 clk = ~clk;

    seven_seg_scan_capture #(
        .SETTLE_CYCLES (16),
        .CNT_W         (5)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .an          (an),
        .seg         (seg),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .value       (value),
        .dp_bits     (dp_bits),
        .seg_err     (seg_err),
        .overrun     (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted frame must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frame", {16'h0, value}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("value", {16'h0, value}, {16'h0, e.val});
                chk("dp_bits", {28'h0, dp_bits}, {28'h0, e.dp});
                chk("seg_err", {28'h0, seg_err}, {28'h0, e.err});
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [7:0] s,
                         input int hold);
        an  = a;
        seg = s;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic scan_digit(input int slot, input logic [31:0] segs,
                              input int hold);
        logic [3:0] a;
        a = ~(4'b0001 << slot);
        drive(a, segs[8*slot +: 8], hold);
    endtask

    task automatic scan_frame(input logic [31:0] segs, input int hold);
        for (int i = 0; i < 4; i++) begin
            scan_digit(i, segs, hold);
        end
        drive(4'hF, 8'hFF, 3);
    endtask

    // With the repeat filter a new frame must be scanned twice to publish.
    task automatic scan_pub(input logic [31:0] segs);
`ifdef SCAN_CONSEC_MATCH_EN
        scan_frame(segs, 20);
`endif
        scan_frame(segs, 20);
    endtask

    task automatic push(input logic [15:0] v, input logic [3:0] d,
                        input logic [3:0] e);
        exp_t x;
        x.val = v;
        x.dp  = d;
        x.err = e;
        exp_q.push_back(x);
    endtask

    initial begin
        // segs packed {an3, an2, an1, an0}
        vecs[0] = '{32'h9F250D99, 16'h1234, 4'b0000, 4'b0000};
        vecs[1] = '{32'h0101FF01, 16'h8808, 4'b0000, 4'b0010};
        vecs[2] = '{32'h71C01102, 16'hFBA0, 4'b0101, 4'b0000};
        vecs[3] = '{32'hFD1F4149, 16'h0765, 4'b0000, 4'b1000};
        vecs[4] = '{32'h09618563, 16'h9EDC, 4'b0000, 4'b0000};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'h0, frame_valid}, 32'h0);
        chk("rst_value", {16'h0, value}, 32'h0);
        chk("rst_dp", {28'h0, dp_bits}, 32'h0);
        chk("rst_err", {28'h0, seg_err}, 32'h0);
        chk("rst_overrun", {31'h0, overrun}, 32'h0);
        rst_n = 1'b1;
        drive(4'hF, 8'hFF, 2);

        for (int i = 0; i < 5; i++) begin
            push(vecs[i].val, vecs[i].dp, vecs[i].err);
            scan_pub(vecs[i].segs);
        end
        chk("overrun_clear", {31'h0, overrun}, 32'h0);

        // Slots held below the settle threshold never latch.
        for (int r = 0; r < 2; r++) begin
            scan_frame(32'h01010101, 10);
        end
        chk("short_hold_valid", {31'h0, frame_valid}, 32'h0);

        // Backpressure across two frames: the newer one wins.
        frame_ready = 1'b0;
        scan_pub(32'h11C16385);
        scan_pub(32'h03710371);
        chk("bp_valid", {31'h0, frame_valid}, 32'h1);
        chk("bp_value", {16'h0, value}, 32'h0F0F);
        chk("bp_overrun", {31'h0, overrun}, 32'h1);
        push(16'h0F0F, 4'h0, 4'h0);
        frame_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_drop", {31'h0, frame_valid}, 32'h0);
        chk("overrun_sticky", {31'h0, overrun}, 32'h1);
        @(posedge clk);
        #1;

        // Reset in the middle of a frame discards the latched slots.
        scan_digit(0, 32'h9F250D99, 20);
        scan_digit(1, 32'h9F250D99, 20);
        rst_n = 1'b0;
        drive(4'hF, 8'hFF, 2);
        chk("mid_rst_value", {16'h0, value}, 32'h0);
        chk("mid_rst_overrun", {31'h0, overrun}, 32'h0);
        chk("mid_rst_valid", {31'h0, frame_valid}, 32'h0);
        rst_n = 1'b1;
        drive(4'hF, 8'hFF, 2);
        scan_digit(2, 32'h411F9949, 20);
        scan_digit(3, 32'h411F9949, 20);
        drive(4'hF, 8'hFF, 3);
        chk("partial_no_frame", {31'h0, frame_valid}, 32'h0);
        push(16'h6745, 4'h0, 4'h0);
        scan_digit(0, 32'h411F9949, 20);
        scan_digit(1, 32'h411F9949, 20);
        drive(4'hF, 8'hFF, 3);
`ifdef SCAN_CONSEC_MATCH_EN
        scan_frame(32'h411F9949, 20);
`endif

        // Consecutive-match sequence.
`ifdef SCAN_CONSEC_MATCH_EN
        push(16'h5556, 4'h0, 4'h0);
`else
        push(16'h5555, 4'h0, 4'h0);
        push(16'h5556, 4'h0, 4'h0);
        push(16'h5556, 4'h0, 4'h0);
`endif
        scan_frame(32'h49494949, 20);
        scan_frame(32'h49494941, 20);
        scan_frame(32'h49494941, 20);
        drive(4'hF, 8'hFF, 5);

        chk("queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
